// File: rtl/booth_mult_seq_if.sv
// Operand/result bundle for booth_mult_seq.
// Handshake: start is accepted on a rising clk edge only while ready=1; done pulses
// for one cycle and product is valid from that cycle until the next completion.
interface booth_mult_seq_if #(
  parameter int WIDTH = 6
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               ready;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic [1:0]         stateDbg;

  modport master (
    output start, signed_mode, a_in, b_in,
    input  ready, busy, done, product, stateDbg
  );

  modport slave (
    input  start, signed_mode, a_in, b_in,
    output ready, busy, done, product, stateDbg
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Radix-2 Booth sequential multiplier (WIDTH+1 iterations, signed or unsigned operands).
// Optional BOOTH_ZERO_SKIP_EN: a zero operand completes in one cycle, bypassing CALC.
module booth_mult_seq #(
  parameter  int WIDTH = 6,
  localparam int CNT_W = $clog2(WIDTH + 2)
) (
  input logic             clk,
  input logic             rst,
  booth_mult_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, stateNext;
  logic [WIDTH:0]     xReg, aReg, yReg;
  logic [WIDTH:0]     xNext, aNext, yNext;
  logic               y1Reg, y1Next;
  logic [CNT_W-1:0]   cnt, cntNext;
  logic [2*WIDTH-1:0] prodReg, prodNext;
  logic [WIDTH:0]     sum;
  logic               accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      xReg    <= '0;
      aReg    <= '0;
      yReg    <= '0;
      y1Reg   <= 1'b0;
      cnt     <= '0;
      prodReg <= '0;
    end else begin
      state   <= stateNext;
      xReg    <= xNext;
      aReg    <= aNext;
      yReg    <= yNext;
      y1Reg   <= y1Next;
      cnt     <= cntNext;
      prodReg <= prodNext;
    end
  end

  always_comb begin
    stateNext = state;
    xNext     = xReg;
    aNext     = aReg;
    yNext     = yReg;
    y1Next    = y1Reg;
    cntNext   = cnt;
    prodNext  = prodReg;
    sum       = aReg;
    accept    = (state != CALC) && bus.start;

    case (state)
      IDLE, DONE: begin
        stateNext = IDLE;
        if (accept) begin
          // Unsigned operands are zero-extended so they act as non-negative signed values.
          xNext     = {bus.signed_mode & bus.a_in[WIDTH-1], bus.a_in};
          yNext     = {bus.signed_mode & bus.b_in[WIDTH-1], bus.b_in};
          aNext     = '0;
          y1Next    = 1'b0;
          cntNext   = CNT_W'(WIDTH + 1);
          stateNext = CALC;
`ifdef BOOTH_ZERO_SKIP_EN
          if ((bus.a_in == '0) || (bus.b_in == '0)) begin
            stateNext = DONE;
            prodNext  = '0;
          end
`else
`endif
        end
      end
      CALC: begin
        case ({yReg[0], y1Reg})
          2'b01:   sum = aReg + xReg;
          2'b10:   sum = aReg - xReg;
          default: sum = aReg;
        endcase
        aNext   = {sum[WIDTH], sum[WIDTH:1]};
        yNext   = {sum[0], yReg[WIDTH:1]};
        y1Next  = yReg[0];
        cntNext = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          stateNext = DONE;
          prodNext  = {aNext[WIDTH-2:0], yNext};
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.ready    = (state != CALC);
  assign bus.busy     = (state == CALC);
  assign bus.done     = (state == DONE);
  assign bus.product  = prodReg;
  assign bus.stateDbg = state;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq (WIDTH=6): directed operands with hand-computed
// products; a negedge monitor checks every done pulse for value and arrival cycle.
module tb_booth_mult_seq;
  localparam int W = 6;
`ifdef BOOTH_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 7;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycleCount = 0;
  int   total = 0;
  int   bad = 0;

  logic [2*W-1:0] exp_q[$];
  int             cyc_q[$];

  booth_mult_seq_if #(.WIDTH(W)) bus ();

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_vs_ready", {31'd0, bus.busy}, {31'd0, !bus.ready});
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cycleCount);
        end else begin
          check("product", 32'(bus.product), 32'(exp_q.pop_front()));
          check("done_cycle", cycleCount, cyc_q.pop_front());
          check("ready_in_done", {31'd0, bus.ready}, 32'd1);
        end
      end
    end
  end

  // driver tasks
  task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         input logic [2*W-1:0] expProd, input bit pushExp, input int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_start", {31'd0, bus.ready}, 32'd1);
    bus.start       = 1'b1;
    bus.a_in        = a;
    bus.b_in        = b;
    bus.signed_mode = sm;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (pushExp) begin
      exp_q.push_back(expProd);
      cyc_q.push_back(cycleCount + lat);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", exp_q.size(), 32'd0);
    exp_q.delete();
    cyc_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int guard;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a_in        = '0;
    bus.b_in        = '0;

    // reset values, held and after release with start=0
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_product", 32'(bus.product), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, bus.ready}, 32'd1);
      check("idle_busy", {31'd0, bus.busy}, 32'd0);
      check("idle_done", {31'd0, bus.done}, 32'd0);
      check("idle_product", 32'(bus.product), 32'd0);
    end

    // boundary and ordinary products
    startOp(6'h20, 6'h20, 1'b1, 12'h400, 1'b1, 7);  // -32 * -32 = 1024
    drain();
    startOp(6'h1F, 6'h20, 1'b1, 12'hC20, 1'b1, 7);  // 31 * -32 = -992
    drain();
    startOp(6'h3F, 6'h3F, 1'b0, 12'hF81, 1'b1, 7);  // 63 * 63 = 3969
    drain();
    startOp(6'h05, 6'h06, 1'b0, 12'h01E, 1'b1, 7);  // 5 * 6 = 30
    drain();

    // start pulsed during CALC is ignored; product holds meanwhile
    startOp(6'h03, 6'h04, 1'b0, 12'h00C, 1'b1, 7);
    repeat (2) @(negedge clk);
    check("prod_hold_calc", 32'(bus.product), 32'h01E);
    check("busy_in_calc", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b1;
    bus.a_in  = 6'h07;
    bus.b_in  = 6'h07;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain();

    // back-to-back start in the DONE cycle
    startOp(6'h03, 6'h3E, 1'b1, 12'hFFA, 1'b1, 7);  // 3 * -2 = -6
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.done && guard < 20);
    check("b2b_done_seen", {31'd0, bus.done}, 32'd1);
    bus.start       = 1'b1;
    bus.a_in        = 6'h3F;
    bus.b_in        = 6'h3F;
    bus.signed_mode = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    exp_q.push_back(12'h001);                        // -1 * -1 = 1
    cyc_q.push_back(cycleCount + 7);
    drain();

    // asynchronous reset during iteration 3 aborts without a done pulse
    startOp(6'h09, 6'h09, 1'b0, 12'h051, 1'b0, 7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", {31'd0, bus.ready}, 32'd1);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_product", 32'(bus.product), 32'd0);
    check("abort_state", {30'd0, bus.stateDbg}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    startOp(6'h09, 6'h09, 1'b0, 12'h051, 1'b1, 7);  // 9 * 9 = 81
    drain();

    // zero operand
    startOp(6'h00, 6'h2F, 1'b1, 12'h000, 1'b1, ZERO_LAT);  // 0 * -17
    drain();

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
